gpio_pattern_sequencer: RTL and testbench

- Timed pattern player for the 38 user-project GPIO pads.
- Holds a small table of pad patterns, each with a hold count, and steps through them autonomously once started.
- Drives io_out/io_oeb for waveform generation and GPIO test sequencing, so firmware does not need one bus write per edge.
- A host-side register slave drives the config port; the pad-facing outputs go to the same io_out/io_oeb nets the user project exposes.

---
 rtl/gpio_pattern_sequencer.sv | 162 ++++++++++++++++
 tb/tb_gpio_pattern_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// gpio_pattern_sequencer
//
// Timed pattern player for the user-project GPIO pads. A small table holds
// pad patterns, each paired with a hold count. Once started, the sequencer
// steps through entries 0..last_idx on its own. Each entry is driven on
// io_out for hold+1 cycles. It can stop at the last entry or wrap to entry 0.
//
// Optional build macro: GPIO_SEQ_CAPTURE_EN
//   When defined, io_in is sampled into cap_data at every step boundary.
//   cap_valid pulses for one cycle right after each capture.
//   When undefined, io_in is unused and the capture ports do not exist.
//
// Ports
//   HCLK, HRESETn    clock, asynchronous active-low reset
//   cfg_we/addr/data/hold   table write: {pattern, hold} at cfg_addr
//   oeb_we, oeb_wdata       direct write of the io_oeb register
//   last_idx         final entry of the sequence, latched at start
//   loop_en          wrap to entry 0 after the last entry; checked at each
//                    step boundary
//   start, stop      single-cycle control pulses (stop has priority)
//   io_in            pad inputs (capture feature only)
//   io_out, io_oeb   registered pad pattern and output enable (1 = input)
//   busy             high while the sequence is running
//   done             one-cycle pulse when the sequence completes naturally
//   seq_idx          index of the entry currently driven
//   cap_data, cap_valid   captured pad inputs (capture feature only)
// ---------------------------------------------------------------------------
module gpio_pattern_sequencer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16,
    parameter int IO_W  = 38,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [IO_W-1:0]  cfg_data,
    input  logic [CNT_W-1:0] cfg_hold,
    input  logic             oeb_we,
    input  logic [IO_W-1:0]  oeb_wdata,
    input  logic [AW-1:0]    last_idx,
    input  logic             loop_en,
    input  logic             start,
    input  logic             stop,
    input  logic [IO_W-1:0]  io_in,
    output logic [IO_W-1:0]  io_out,
    output logic [IO_W-1:0]  io_oeb,
    output logic             busy,
    output logic             done,
`ifdef GPIO_SEQ_CAPTURE_EN
    output logic [IO_W-1:0]  cap_data,
    output logic             cap_valid,
`endif
    output logic [AW-1:0]    seq_idx
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [AW-1:0] IDX0 = '0;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [AW-1:0]    last_reg;

    // Pattern table. It has no reset, and writes are allowed at any time.
    // The playing entry has already been copied into io_out/cnt_reg, so a
    // rewrite only takes effect the next time that entry is loaded.
    logic [IO_W-1:0]  pat_mem  [DEPTH];
    logic [CNT_W-1:0] hold_mem [DEPTH];

    always_ff @(posedge HCLK) begin
        if (cfg_we) begin
            pat_mem[cfg_addr]  <= cfg_data;
            hold_mem[cfg_addr] <= cfg_hold;
        end
    end

    // Index to load at a step boundary. The wrap to 0 happens in the same
    // edge as the boundary, so a looped sequence has no dead cycle.
    logic          at_last;
    logic [AW-1:0] next_idx;

    always_comb begin
        at_last  = (seq_idx == last_reg);
        next_idx = at_last ? IDX0 : seq_idx + AW'(1);
    end

`ifndef GPIO_SEQ_CAPTURE_EN
    logic unused_io_in;
    assign unused_io_in = ^io_in;
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            last_reg  <= '0;
            io_out    <= '0;
            io_oeb    <= '1;
            busy      <= 1'b0;
            done      <= 1'b0;
            seq_idx   <= '0;
`ifdef GPIO_SEQ_CAPTURE_EN
            cap_data  <= '0;
            cap_valid <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef GPIO_SEQ_CAPTURE_EN
            cap_valid <= 1'b0;
`endif
            if (oeb_we) begin
                io_oeb <= oeb_wdata;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (start && !stop) begin
                        io_out    <= pat_mem[IDX0];
                        cnt_reg   <= hold_mem[IDX0];
                        seq_idx   <= IDX0;
                        last_reg  <= last_idx;
                        busy      <= 1'b1;
                        state_reg <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (stop) begin
                        // Abort: io_out and seq_idx freeze, and no done pulse.
                        busy      <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end else begin
`ifdef GPIO_SEQ_CAPTURE_EN
                        cap_data  <= io_in;
                        cap_valid <= 1'b1;
`endif
                        if (!at_last || loop_en) begin
                            seq_idx <= next_idx;
                            io_out  <= pat_mem[next_idx];
                            cnt_reg <= hold_mem[next_idx];
                        end else begin
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state_reg <= ST_IDLE;
                        end
                    end
                end

                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_pattern_sequencer.sv
module tb_gpio_pattern_sequencer;

    localparam int DEPTH = 8;
    localparam int CNT_W = 16;
    localparam int IO_W  = 38;
    localparam int AW    = 3;

    logic             HCLK = 1'b0;
    logic             HRESETn;
    logic             cfg_we;
    logic [AW-1:0]    cfg_addr;
    logic [IO_W-1:0]  cfg_data;
    logic [CNT_W-1:0] cfg_hold;
    logic             oeb_we;
    logic [IO_W-1:0]  oeb_wdata;
    logic [AW-1:0]    last_idx;
    logic             loop_en;
    logic             start;
    logic             stop;
    logic [IO_W-1:0]  io_in;
    logic [IO_W-1:0]  io_out;
    logic [IO_W-1:0]  io_oeb;
    logic             busy;
    logic             done;
    logic [AW-1:0]    seq_idx;
`ifdef GPIO_SEQ_CAPTURE_EN
    logic [IO_W-1:0]  cap_data;
    logic             cap_valid;
`endif

    always #5 HCLK = ~HCLK;

    gpio_pattern_sequencer #(
        .DEPTH(DEPTH),
        .CNT_W(CNT_W),
        .IO_W (IO_W)
    ) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .cfg_hold (cfg_hold),
        .oeb_we   (oeb_we),
        .oeb_wdata(oeb_wdata),
        .last_idx (last_idx),
        .loop_en  (loop_en),
        .start    (start),
        .stop     (stop),
        .io_in    (io_in),
        .io_out   (io_out),
        .io_oeb   (io_oeb),
        .busy     (busy),
        .done     (done),
`ifdef GPIO_SEQ_CAPTURE_EN
        .cap_data (cap_data),
        .cap_valid(cap_valid),
`endif
        .seq_idx  (seq_idx)
    );

    typedef struct {
        logic [IO_W-1:0] io;
        logic            busy;
        logic            done;
        logic [AW-1:0]   idx;
        string           tag;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int cap_cnt = 0;
    logic [IO_W-1:0] cap_exp = '0;
    localparam logic [IO_W-1:0] ALL1 = '1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // The expected output after the next edge goes into the scoreboard.
    task automatic push(input logic [IO_W-1:0] io, input logic b, input logic d,
                        input logic [AW-1:0] idx, input string tag);
        exp_t e;
        e.io = io; e.busy = b; e.done = d; e.idx = idx; e.tag = tag;
        sb.push_back(e);
    endtask

    // Advance one clock, sample 1 time unit after the edge, and retire the
    // oldest scoreboard entry.
    task automatic tick_check();
        exp_t e;
        @(posedge HCLK);
        #1;
        if (sb.size() == 0) begin
            chk("sb_underflow", 64'(1), 64'(0));
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".io_out"}, 64'(io_out), 64'(e.io));
            chk({e.tag, ".busy"},   64'(busy),   64'(e.busy));
            chk({e.tag, ".done"},   64'(done),   64'(e.done));
            chk({e.tag, ".seq_idx"}, 64'(seq_idx), 64'(e.idx));
            $display("cycle %s: io_out=%h busy=%0d done=%0d seq_idx=%0d",
                     e.tag, io_out, busy, done, seq_idx);
        end
`ifdef GPIO_SEQ_CAPTURE_EN
        if (cap_valid) begin
            cap_cnt++;
            chk({e.tag, ".cap_data"}, 64'(cap_data), 64'(cap_exp));
        end
`endif
    endtask

    task automatic step(input logic [IO_W-1:0] io, input logic b, input logic d,
                        input logic [AW-1:0] idx, input string tag);
        push(io, b, d, idx, tag);
        tick_check();
    endtask

    task automatic write_entry(input logic [AW-1:0] a, input logic [IO_W-1:0] d,
                               input logic [CNT_W-1:0] h);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d; cfg_hold = h;
        @(posedge HCLK);
        #1;
        cfg_we = 1'b0;
        $display("write entry %0d: data=%h hold=%0d", a, d, h);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESETn = 1'b0;
        cfg_we = 0; cfg_addr = '0; cfg_data = '0; cfg_hold = '0;
        oeb_we = 0; oeb_wdata = '0; last_idx = '0; loop_en = 0;
        start = 0; stop = 0; io_in = '0;

        // Reset state
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
        chk("rst.io_out", 64'(io_out), 64'(0));
        chk("rst.io_oeb", 64'(io_oeb), 64'(38'h3F_FFFF_FFFF));
        chk("rst.busy",   64'(busy),   64'(0));
        chk("rst.done",   64'(done),   64'(0));
        chk("rst.seq_idx", 64'(seq_idx), 64'(0));
`ifdef GPIO_SEQ_CAPTURE_EN
        chk("rst.cap_data", 64'(cap_data), 64'(0));
`endif

        // The io_oeb register follows oeb_we.
        oeb_we = 1'b1; oeb_wdata = 38'h15_0000_00FF;
        @(posedge HCLK);
        #1;
        oeb_we = 1'b0;
        chk("oeb.write", 64'(io_oeb), 64'(38'h15_0000_00FF));

        write_entry(3'd0, 38'h1, 16'd2);
        write_entry(3'd1, 38'h2, 16'd0);
        write_entry(3'd2, 38'h4, 16'd1);

        // One-shot run: 1,1,1,2,4,4 then done
        last_idx = 3'd2; loop_en = 1'b0; start = 1'b1;
        step(38'h1, 1, 0, 0, "once0");
        start = 1'b0;
        step(38'h1, 1, 0, 0, "once1");
        step(38'h1, 1, 0, 0, "once2");
        step(38'h2, 1, 0, 1, "once3");
        step(38'h4, 1, 0, 2, "once4");
        step(38'h4, 1, 0, 2, "once5");
        step(38'h4, 0, 1, 2, "once_done");
        step(38'h4, 0, 0, 2, "once_idle");

        // Looping run. Wrap with no gap, then clear loop_en during entry1.
        loop_en = 1'b1; start = 1'b1;
        step(38'h1, 1, 0, 0, "loop0");
        start = 1'b0;
        step(38'h1, 1, 0, 0, "loop1");
        step(38'h1, 1, 0, 0, "loop2");
        step(38'h2, 1, 0, 1, "loop3");
        step(38'h4, 1, 0, 2, "loop4");
        step(38'h4, 1, 0, 2, "loop5");
        step(38'h1, 1, 0, 0, "loop_wrap");
        step(38'h1, 1, 0, 0, "loop7");
        step(38'h1, 1, 0, 0, "loop8");
        step(38'h2, 1, 0, 1, "loop9");
        loop_en = 1'b0;
        step(38'h4, 1, 0, 2, "loop10");
        step(38'h4, 1, 0, 2, "loop11");
        step(38'h4, 0, 1, 2, "loop_done");

        // Abort during entry1. A start in the same cycle is ignored.
        start = 1'b1;
        step(38'h1, 1, 0, 0, "stop0");
        start = 1'b0;
        step(38'h1, 1, 0, 0, "stop1");
        step(38'h1, 1, 0, 0, "stop2");
        step(38'h2, 1, 0, 1, "stop3");
        stop = 1'b1; start = 1'b1;
        step(38'h2, 0, 0, 1, "stop_abort");
        step(38'h2, 0, 0, 1, "stop_idle_both");
        stop = 1'b0; start = 1'b0;
        step(38'h2, 0, 0, 1, "stop_idle");

        // Asynchronous reset during a long hold
        write_entry(3'd2, 38'h4, 16'hFFFF);
        start = 1'b1;
        step(38'h1, 1, 0, 0, "ar0");
        start = 1'b0;
        step(38'h1, 1, 0, 0, "ar1");
        step(38'h1, 1, 0, 0, "ar2");
        step(38'h2, 1, 0, 1, "ar3");
        step(38'h4, 1, 0, 2, "ar4");
        step(38'h4, 1, 0, 2, "ar5");
        step(38'h4, 1, 0, 2, "ar6");
        #2;
        HRESETn = 1'b0;
        #1;
        chk("arst.io_out", 64'(io_out), 64'(0));
        chk("arst.io_oeb", 64'(io_oeb), 64'(ALL1));
        chk("arst.busy",   64'(busy),   64'(0));
        chk("arst.seq_idx", 64'(seq_idx), 64'(0));
        $display("async reset asserted: io_out=%h io_oeb=%h busy=%0d", io_out, io_oeb, busy);
        @(posedge HCLK);
        #3;
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
        chk("arst.still_idle", 64'(busy), 64'(0));
        start = 1'b1;
        step(38'h1, 1, 0, 0, "post0");
        start = 1'b0;
        step(38'h1, 1, 0, 0, "post1");
        step(38'h1, 1, 0, 0, "post2");
        step(38'h2, 1, 0, 1, "post3");
        stop = 1'b1;
        step(38'h2, 0, 0, 1, "post_stop");
        stop = 1'b0;

        // Capture run with three entries
        write_entry(3'd2, 38'h4, 16'd1);
        io_in = 38'h2A_5A5A_5A5A;
        cap_exp = 38'h2A_5A5A_5A5A;
        cap_cnt = 0;
        start = 1'b1;
        step(38'h1, 1, 0, 0, "cap0");
        start = 1'b0;
        step(38'h1, 1, 0, 0, "cap1");
        step(38'h1, 1, 0, 0, "cap2");
        step(38'h2, 1, 0, 1, "cap3");
        step(38'h4, 1, 0, 2, "cap4");
        step(38'h4, 1, 0, 2, "cap5");
        step(38'h4, 0, 1, 2, "cap_done");
        step(38'h4, 0, 0, 2, "cap_idle");
`ifdef GPIO_SEQ_CAPTURE_EN
        chk("cap.pulse_count", 64'(cap_cnt), 64'(3));
`endif

        chk("sb.drained", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
